// File: rtl/fifo_pkg.sv
// Shared types and parameter-legality helpers for the parametrised FWFT FIFO.
// The status struct is exported for the register-map block.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit params_legal(input int dw, input int depth,
                                      input int af_th, input int ae_th);
    return (dw >= 1) && is_pow2(depth) &&
           (af_th >= 1) && (af_th <= depth) &&
           (ae_th >= 0) && (ae_th <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer: AW index bits plus one wrap bit, counting modulo 2^(AW+1).
// Used for both the write and read side of the FIFO.
module fifo_ptr #(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [AW:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + (AW + 1)'(1);
    end
  end

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock first-word-fall-through FIFO with occupancy, thresholds,
// synchronous flush and sticky overflow/underflow flags.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int AF_TH = DEPTH - 2,
  parameter int AE_TH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr,
  input  logic [DW-1:0]              data_fifo,
  input  logic                       mstr0_ready,
  output logic [DW-1:0]              mstr0_data,
  output logic                       data_valid,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     level,
  input  logic                       flush,
  output logic                       overflow,
  input  logic                       clr_err,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AF_LVL = (AW + 1)'(AF_TH);
  localparam logic [AW:0] AE_LVL = (AW + 1)'(AE_TH);

  if (!params_legal(DW, DEPTH, AF_TH, AE_TH)) begin : g_bad_params
    $error("fifo_sync_param: illegal DW/DEPTH/AF_TH/AE_TH combination");
  end

  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [AW:0]   occupancy;
  logic          push;
  logic          pop;
  logic          mem_we;
  logic          ovf_q;
  logic          udf_q;
  fifo_status_t  status;
  logic [DW-1:0] mem [DEPTH];

  // Accept decisions use only the registered flags, so wr/ready never reach status.
  assign push   = wr & ~status.full;
  assign pop    = mstr0_ready & ~status.empty;
  assign mem_we = push & ~flush & ~rst;

  fifo_ptr #(.AW(AW)) u_wptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (push),
    .ptr (wptr)
  );

  fifo_ptr #(.AW(AW)) u_rptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (pop),
    .ptr (rptr)
  );

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wptr[AW-1:0]] <= data_fifo;
    end
  end

  // Sticky errors: a fresh set condition beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wr && status.full) begin
        ovf_q <= 1'b1;
      end else if (clr_err) begin
        ovf_q <= 1'b0;
      end
      if (mstr0_ready && status.empty) begin
        udf_q <= 1'b1;
      end else if (clr_err) begin
        udf_q <= 1'b0;
      end
    end
  end

  assign occupancy           = wptr - rptr;
  assign status.empty        = (wptr == rptr);
  assign status.full         = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign status.almost_full  = (occupancy >= AF_LVL);
  assign status.almost_empty = (occupancy <= AE_LVL);
  assign status.overflow     = ovf_q;
  assign status.underflow    = udf_q;

  assign mstr0_data   = mem[rptr[AW-1:0]];
  assign data_valid   = ~status.empty;
  assign fifo_full    = status.full;
  assign fifo_empty   = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;
  assign level        = occupancy;
  assign overflow     = status.overflow;
  assign underflow    = status.underflow;

endmodule
